cipher_char_decrypt: RTL and testbench

- Streaming character decryption engine; the receive-side counterpart of public key generation.
- Accepts a public key, recovers the secret key as Sk = (Pk + 2) mod 227, which is the inverse of Pk = (Sk + 225) mod 227.
- Decrypts a stream of cipher bytes as M = (C − Sk) mod 227.
- Sits between the channel receiver and the plaintext sink; valid/ready handshakes on both cipher input and plain output.

---
 rtl/cipher_char_decrypt.sv | 113 +++++++++++
 tb/tb_cipher_char_decrypt.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_char_decrypt.sv
// cipher_char_decrypt: streaming mod-227 character decryption with public-key recovery; `DEC_CHAR_COUNT_EN adds dec_count
module cipher_char_decrypt #(
  parameter int P_PAR = 227,
  parameter int Q_PAR = 225
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] Public_key,
  input  logic       pk_load,
  input  logic [7:0] cipher_char,
  input  logic       cipher_valid,
  output logic       cipher_ready,
  output logic [7:0] plain_char,
  output logic       plain_valid,
  input  logic       plain_ready,
  output logic       key_ready,
  output logic       err_invalid_pubkey,
  output logic       err_invalid_char
`ifdef DEC_CHAR_COUNT_EN
  ,output logic [15:0] dec_count
`endif
);
  typedef enum logic [2:0] {IDLE, KEYCHK, READY, DEC, OUT} state_e;
  localparam logic [8:0] P9 = 9'(P_PAR);
  localparam logic [8:0] ADD9 = 9'(P_PAR - Q_PAR);
  localparam logic [7:0] PMAX = 8'(P_PAR - 1);
  localparam logic [7:0] QK = 8'(Q_PAR);
  state_e state_q, state_d;
  logic [7:0] pk_q, pk_d, sk_q, sk_d, c_q, c_d, plain_q, plain_d;
  logic err_pk_q, err_pk_d, err_ch_q, err_ch_d;
  logic [8:0] sk_sum, c9, s9;
  logic mode_dec, pk_bad, c_bad;
  assign mode_dec = mode == 2'b01;
  assign sk_sum = {1'b0, pk_q} + ADD9;
  assign c9 = {1'b0, c_q};
  assign s9 = {1'b0, sk_q};
  assign pk_bad = pk_q > PMAX || pk_q == QK;
  assign c_bad = c_q > PMAX;
  assign cipher_ready = state_q == READY;
  assign plain_valid = state_q == OUT;
  assign key_ready = state_q == READY || state_q == DEC || state_q == OUT;
  assign plain_char = plain_q;
  assign err_invalid_pubkey = err_pk_q;
  assign err_invalid_char = err_ch_q;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pk_q     <= '0;
      sk_q     <= '0;
      c_q      <= '0;
      plain_q  <= '0;
      err_pk_q <= 1'b0;
      err_ch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pk_q     <= pk_d;
      sk_q     <= sk_d;
      c_q      <= c_d;
      plain_q  <= plain_d;
      err_pk_q <= err_pk_d;
      err_ch_q <= err_ch_d;
    end
  end
  // next state: leaving decrypt mode flushes to IDLE, otherwise key check and byte pipeline
  always_comb begin
    state_d  = state_q;
    pk_d     = pk_q;
    sk_d     = sk_q;
    c_d      = c_q;
    plain_d  = plain_q;
    err_pk_d = err_pk_q;
    err_ch_d = 1'b0;
    if (!mode_dec) state_d = IDLE;
    else case (state_q)
      IDLE: if (pk_load) begin
        pk_d    = Public_key;
        state_d = KEYCHK;
      end
      KEYCHK: begin
        err_pk_d = pk_bad;
        sk_d     = pk_bad ? sk_q : 8'(sk_sum >= P9 ? sk_sum - P9 : sk_sum);
        state_d  = pk_bad ? IDLE : READY;
      end
      READY: if (pk_load) begin
        pk_d    = Public_key;
        state_d = KEYCHK;
      end else if (cipher_valid) begin
        c_d     = cipher_char;
        state_d = DEC;
      end
      DEC: begin
        err_ch_d = c_bad;
        plain_d  = c_bad ? plain_q : 8'(c9 >= s9 ? c9 - s9 : c9 + P9 - s9);
        state_d  = c_bad ? READY : OUT;
      end
      OUT: state_d = plain_ready ? READY : OUT;
      default: state_d = IDLE;
    endcase
  end
`ifdef DEC_CHAR_COUNT_EN
  logic [15:0] cnt_q;
  logic pk_acc;
  assign pk_acc = mode_dec && pk_load && (state_q == IDLE || state_q == READY);
  assign dec_count = cnt_q;
  // count delivered bytes, restarting with each accepted key
  always_ff @(posedge clk) begin
    if (!rst_n || pk_acc) cnt_q <= '0;
    else if (plain_valid && plain_ready) cnt_q <= cnt_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cipher_char_decrypt.sv
// tb_cipher_char_decrypt: vector table plus scoreboard checks for cipher_char_decrypt
module tb_cipher_char_decrypt;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] Public_key = '0;
  logic pk_load = 1'b0;
  logic [7:0] cipher_char = '0;
  logic cipher_valid = 1'b0;
  logic cipher_ready;
  logic [7:0] plain_char;
  logic plain_valid;
  logic plain_ready = 1'b1;
  logic key_ready;
  logic err_invalid_pubkey;
  logic err_invalid_char;
`ifdef DEC_CHAR_COUNT_EN
  logic [15:0] dec_count;
`endif
  cipher_char_decrypt dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .Public_key(Public_key),
    .pk_load(pk_load),
    .cipher_char(cipher_char),
    .cipher_valid(cipher_valid),
    .cipher_ready(cipher_ready),
    .plain_char(plain_char),
    .plain_valid(plain_valid),
    .plain_ready(plain_ready),
    .key_ready(key_ready),
    .err_invalid_pubkey(err_invalid_pubkey),
    .err_invalid_char(err_invalid_char)
`ifdef DEC_CHAR_COUNT_EN
    ,.dec_count(dec_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] pk;
    logic [7:0] c;
    logic [7:0] m;
    logic       bad;
  } vec_t;
  vec_t vecs[17];
  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask
  // scoreboard: every plain handshake must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_n && mode == 2'b01 && plain_valid && plain_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got plain_char %0d, required no output", plain_char);
      end else chk("sb_plain_char", {8'h00, plain_char}, {8'h00, exp_q.pop_front()});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int n = 0;
    do begin
      step();
      n++;
    end while (!cipher_ready && n < 20);
    chk("cipher_ready_wait", cipher_ready, 1);
  endtask
  task automatic load_key(input logic [7:0] pk, input logic ok);
    step();
    pk_load = 1'b1;
    Public_key = pk;
    step();
    pk_load = 1'b0;
    chk("keychk_key_ready", key_ready, 0);
    chk("keychk_cipher_ready", cipher_ready, 0);
    step();
    chk("key_ready", key_ready, ok);
    chk("err_invalid_pubkey", err_invalid_pubkey, !ok);
    chk("cipher_ready_after_key", cipher_ready, ok);
  endtask
  task automatic send(input logic [7:0] c, input logic [7:0] m, input logic bad);
    wait_ready();
    cipher_valid = 1'b1;
    cipher_char = c;
    if (!bad) exp_q.push_back(m);
    step();
    cipher_valid = 1'b0;
    chk("dec_cipher_ready", cipher_ready, 0);
    chk("dec_plain_valid", plain_valid, 0);
    step();
    if (bad) begin
      chk("bad_err_char", err_invalid_char, 1);
      chk("bad_no_plain", plain_valid, 0);
      chk("bad_ready_again", cipher_ready, 1);
      step();
      chk("bad_err_pulse_end", err_invalid_char, 0);
    end else begin
      chk("latency_plain_valid", plain_valid, 1);
      chk("good_no_err_char", err_invalid_char, 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
  initial begin
    logic [7:0] cur_pk;
    vecs[0]  = '{8'd0,   8'd5,   8'd3,   1'b0};
    vecs[1]  = '{8'd0,   8'd1,   8'd226, 1'b0};
    vecs[2]  = '{8'd0,   8'd0,   8'd225, 1'b0};
    vecs[3]  = '{8'd0,   8'd226, 8'd224, 1'b0};
    vecs[4]  = '{8'd0,   8'd228, 8'd0,   1'b1};
    vecs[5]  = '{8'd0,   8'd2,   8'd0,   1'b0};
    vecs[6]  = '{8'd0,   8'd227, 8'd0,   1'b1};
    vecs[7]  = '{8'd0,   8'd255, 8'd0,   1'b1};
    vecs[8]  = '{8'd226, 8'd0,   8'd226, 1'b0};
    vecs[9]  = '{8'd226, 8'd1,   8'd0,   1'b0};
    vecs[10] = '{8'd226, 8'd200, 8'd199, 1'b0};
    vecs[11] = '{8'd100, 8'd50,  8'd175, 1'b0};
    vecs[12] = '{8'd100, 8'd102, 8'd0,   1'b0};
    vecs[13] = '{8'd100, 8'd226, 8'd124, 1'b0};
    vecs[14] = '{8'd224, 8'd0,   8'd1,   1'b0};
    vecs[15] = '{8'd224, 8'd226, 8'd0,   1'b0};
    vecs[16] = '{8'd224, 8'd225, 8'd226, 1'b0};
    repeat (3) step();
    chk("rst_cipher_ready", cipher_ready, 0);
    chk("rst_plain_valid", plain_valid, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_plain_char", {8'h00, plain_char}, 0);
    chk("rst_err_pubkey", err_invalid_pubkey, 0);
    chk("rst_err_char", err_invalid_char, 0);
    rst_n = 1'b1;
    pk_load = 1'b1;
    Public_key = 8'd0;
    step();
    pk_load = 1'b0;
    step();
    chk("idle_mode00_pk_ignored", key_ready, 0);
    mode = 2'b01;
    cur_pk = 8'hff;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].pk != cur_pk) begin
        load_key(vecs[i].pk, 1'b1);
        cur_pk = vecs[i].pk;
      end
      send(vecs[i].c, vecs[i].m, vecs[i].bad);
    end
    load_key(8'd0, 1'b1);
    plain_ready = 1'b0;
    wait_ready();
    cipher_valid = 1'b1;
    cipher_char = 8'd100;
    exp_q.push_back(8'd98);
    step();
    cipher_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_plain_valid", plain_valid, 1);
      chk("bp_plain_char", {8'h00, plain_char}, 16'd98);
      chk("bp_cipher_ready", cipher_ready, 0);
      step();
    end
    plain_ready = 1'b1;
    step();
    chk("bp_release_valid", plain_valid, 0);
    chk("bp_release_ready", cipher_ready, 1);
    plain_ready = 1'b0;
    wait_ready();
    cipher_valid = 1'b1;
    cipher_char = 8'd10;
    step();
    cipher_valid = 1'b0;
    step();
    chk("drop_out_valid", plain_valid, 1);
    mode = 2'b00;
    step();
    chk("drop_plain_valid", plain_valid, 0);
    chk("drop_key_ready", key_ready, 0);
    chk("drop_cipher_ready", cipher_ready, 0);
    plain_ready = 1'b1;
    pk_load = 1'b1;
    Public_key = 8'd5;
    step();
    pk_load = 1'b0;
    step();
    chk("mode00_pk_ignored", key_ready, 0);
    mode = 2'b01;
    load_key(8'd225, 1'b0);
    load_key(8'd230, 1'b0);
    repeat (3) step();
    chk("badkey_cipher_ready", cipher_ready, 0);
    mode = 2'b00;
    step();
    chk("drop_err_pubkey_hold", err_invalid_pubkey, 1);
    mode = 2'b01;
    load_key(8'd0, 1'b1);
    wait_ready();
    cipher_valid = 1'b1;
    cipher_char = 8'd5;
    step();
    cipher_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rstdec_cipher_ready", cipher_ready, 0);
    chk("rstdec_plain_valid", plain_valid, 0);
    chk("rstdec_key_ready", key_ready, 0);
    chk("rstdec_plain_char", {8'h00, plain_char}, 0);
    chk("rstdec_err_char", err_invalid_char, 0);
    rst_n = 1'b1;
`ifdef DEC_CHAR_COUNT_EN
    chk("cnt_reset", dec_count, 0);
    load_key(8'd0, 1'b1);
    send(8'd5, 8'd3, 1'b0);
    send(8'd1, 8'd226, 1'b0);
    send(8'd9, 8'd7, 1'b0);
    step();
    chk("cnt_three", dec_count, 3);
    load_key(8'd7, 1'b1);
    chk("cnt_cleared", dec_count, 0);
`endif
    repeat (3) step();
    chk("sb_empty", 16'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
